// File: rtl/boot_ctrl_if.sv
// Loader, CPU-fetch and memory-port signals of the boot sequencer, grouped for one port.
// The slave side is the sequencer; the master side is whatever drives it.
interface boot_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start_load;
    logic                  ld_ready;
    logic                  ld_prog_rdy;
    logic                  ld_inst_rdy;
    logic [ADDR_WIDTH-1:0] ld_wr_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_rx_byte;
    logic [ADDR_WIDTH-1:0] cpu_imem_addr;
    logic                  ld_next_program;
    logic                  ld_clear;
    logic                  cpu_rst;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  load_error;
    logic [7:0]            programs_loaded;
    logic [2:0]            ctrl_state;

    modport slave (
        input  start_load, ld_ready, ld_prog_rdy, ld_inst_rdy, ld_wr_addr, ld_data,
               ld_rx_byte, cpu_imem_addr,
        output ld_next_program, ld_clear, cpu_rst, mem_we, mem_addr, mem_wdata,
               load_error, programs_loaded, ctrl_state
    );

    modport master (
        output start_load, ld_ready, ld_prog_rdy, ld_inst_rdy, ld_wr_addr, ld_data,
               ld_rx_byte, cpu_imem_addr,
        input  ld_next_program, ld_clear, cpu_rst, mem_we, mem_addr, mem_wdata,
               load_error, programs_loaded, ctrl_state
    );
endinterface

// File: rtl/boot_ctrl.sv
// Boot/run sequencer: holds the CPU in reset while the UART loader fills instruction
// memory, hands the memory port over on program ready, and recovers a stalled loader.
module boot_ctrl #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    boot_ctrl_if.slave  bus
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_RUN   = 3'd1,
        S_REQ   = 3'd2,
        S_CLEAN = 3'd3,
        S_ERROR = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WD_W-1:0] r_wd_cnt;
    logic [WD_W-1:0] w_wd_nxt;
    logic [7:0]      r_prog_cnt;
    logic [7:0]      w_prog_nxt;
    logic            w_wd_kick;

    assign w_wd_kick = bus.ld_ready | bus.ld_rx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_wd_cnt   <= '0;
            r_prog_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wd_cnt   <= w_wd_nxt;
            r_prog_cnt <= w_prog_nxt;
        end
    end

    // The watchdog only counts in LOAD; every other state leaves it at zero so any
    // return to LOAD starts a fresh timeout window.
    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = '0;
        w_prog_nxt  = r_prog_cnt;
        case (r_state)
            S_LOAD: begin
                if (bus.ld_prog_rdy) begin
                    w_state_nxt = S_RUN;
                    if (r_prog_cnt != 8'hFF) begin
                        w_prog_nxt = r_prog_cnt + 8'd1;
                    end
                end else if (w_wd_kick) begin
                    w_wd_nxt = '0;
                end else if (r_wd_cnt == WD_LAST) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wd_nxt = r_wd_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.start_load) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_state_nxt = S_CLEAN;
            end
            S_CLEAN: begin
                if (bus.ld_ready) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_ERROR: begin
                if (bus.start_load) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_LOAD;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Memory port mux; ERROR and FLUSH park the port so a misbehaving loader cannot write.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_LOAD, S_REQ, S_CLEAN: begin
                bus.mem_we    = bus.ld_inst_rdy;
                bus.mem_addr  = bus.ld_wr_addr;
                bus.mem_wdata = bus.ld_data;
            end
            S_RUN: begin
                bus.mem_addr = bus.cpu_imem_addr;
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    assign bus.cpu_rst         = (r_state != S_RUN);
    assign bus.ld_next_program = (r_state == S_REQ);
    assign bus.load_error      = (r_state == S_ERROR);
    assign bus.ld_clear        = rst | (r_state == S_FLUSH);
    assign bus.ctrl_state      = r_state;
    assign bus.programs_loaded = r_prog_cnt;

endmodule

// File: doc/boot_ctrl.md
Name: boot_ctrl

Overview:
Boot/run sequencer for the UART program loader and the instruction memory it fills.
- Holds the CPU in reset while a program is loaded.
- Hands the memory port to the CPU once the loader signals program ready.
- On user request, has the loader zero the memory and reload.
- Watchdogs the UART byte stream and recovers a stalled loader.

Parameters:
ADDR_WIDTH, 10, instruction memory address width
DATA_WIDTH, 32, instruction word width
TIMEOUT_CYCLES, 1000000, idle clocks between loader bytes before a load is declared failed (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_load  in  1  user request (pulse or level) to load a new program
ld_ready  in  1  loader idle, waiting for the instruction-count byte
ld_prog_rdy  in  1  loader holds a complete program
ld_inst_rdy  in  1  loader write strobe
ld_wr_addr  in  ADDR_WIDTH  loader write address
ld_data  in  DATA_WIDTH  loader write data
ld_rx_byte  in  1  UART rx_done, the same strobe that feeds the loader
cpu_imem_addr  in  ADDR_WIDTH  CPU fetch address
ld_next_program  out  1  one-cycle request for the loader to clean memory and re-arm
ld_clear  out  1  loader reset
cpu_rst  out  1  CPU reset, active-high
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
load_error  out  1  set on watchdog timeout
programs_loaded  out  8  count of successful loads, saturating
ctrl_state  out  3  current state encoding

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, sampled on the rising edge.
- States: LOAD=0, RUN=1, REQ=2, CLEAN=3, ERROR=4, FLUSH=5. Reset state is LOAD.
- Values while and after rst:
  - state=LOAD, wd_cnt=0, programs_loaded=0, load_error=0.
  - cpu_rst=1, ld_next_program=0.
  - ld_clear=1 while rst is high (ld_clear = rst OR state==FLUSH).
- Derived outputs, combinational from state_reg:
  - cpu_rst = (state != RUN).
  - ld_next_program = (state == REQ).
  - load_error = (state == ERROR).
  - ctrl_state = state.
- Memory port mux, zero latency:
  - Loader owns the port in LOAD, REQ and CLEAN: mem_we=ld_inst_rdy, mem_addr=ld_wr_addr, mem_wdata=ld_data.
  - CPU owns it in RUN: mem_we=0, mem_addr=cpu_imem_addr, mem_wdata=0.
  - ERROR and FLUSH: mem_we=0, mem_addr=0, mem_wdata=0. Writes from a misbehaving loader are blocked.
- LOAD:
  - ld_prog_rdy=1 -> RUN; programs_loaded+1, saturating at 255. cpu_rst is low in the first RUN cycle, i.e. one edge after ld_prog_rdy is sampled.
  - Otherwise the watchdog runs. wd_cnt clears when ld_ready=1 or ld_rx_byte=1; else it increments.
  - When wd_cnt==TIMEOUT_CYCLES-1 and it would increment -> ERROR.
  - ld_prog_rdy and timeout in the same cycle: RUN wins.
  - start_load is ignored.
- RUN: start_load=1 -> REQ. The loader is in its done state here.
- REQ: lasts exactly 1 cycle (ld_next_program=1), then -> CLEAN.
- CLEAN:
  - The loader writes zeros via its strobe; the mux passes them through.
  - ld_ready=1 -> LOAD with wd_cnt=0. No watchdog runs; cleaning is bounded at 256 writes.
  - start_load is ignored.
- ERROR: held until start_load=1 -> FLUSH.
- FLUSH: lasts 1 cycle (ld_clear=1), then -> LOAD with wd_cnt=0.
- wd_cnt: width clog2(TIMEOUT_CYCLES+1); never wraps.
- Held-level start_load: after reloading, RUN goes straight to REQ again. This is required behaviour; pulse-drive the input for a single reload.
- rst mid-operation, any state: next state LOAD, counters cleared, in-flight memory write suppressed from the next cycle.
- Unreachable encodings 6/7 -> LOAD.

Test Plan:
1. Post-reset load: rst for 2 cycles. Drive loader traffic with count byte 2 and 8 data bytes; loader emits strobes at addr 0 and 4; ld_prog_rdy rises.
   -> mem_we follows both strobes with matching addr/data; cpu_rst falls one edge after ld_prog_rdy; programs_loaded=1; state=1.
2. CPU fetch: in RUN, cpu_imem_addr=0x08 with ld_inst_rdy forced 1.
   -> mem_addr=0x08, mem_we=0.
3. Reload: start_load pulse in RUN.
   -> REQ for exactly one cycle with ld_next_program=1; cpu_rst=1; CLEAN passes zero-data strobes to addr 0 and 4.
   -> ld_ready returns -> LOAD; second load -> programs_loaded=2.
4. Watchdog (TIMEOUT_CYCLES=16): count byte plus 1 data byte, then silence.
   -> ERROR 16 cycles after the last byte; load_error=1; mem_we stays 0 despite ld_inst_rdy.
   -> start_load -> one FLUSH cycle with ld_clear=1 -> LOAD; load_error=0.
5. Tie break: ld_prog_rdy asserted on the exact timeout cycle.
   -> RUN, load_error stays 0.
6. Mid-load reset: rst during CLEAN.
   -> next cycle state=0, ld_clear=1 during rst, programs_loaded=0, cpu_rst=1, mem_we=0.
